// File: rtl/iecdrv_pkg.sv
// Shared types and constants for the drive ROM loader arbiter.
// Backing memory is byte addressed; each drive image is 32 KB.
package iecdrv_pkg;

  localparam int ADDR_W   = 25;
  localparam int IMG_SIZE = 32768;
  localparam int IMG_AW   = $clog2(IMG_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_GAP
  } state_e;

  // bank selects a 32 KB window above base
  function automatic logic [ADDR_W-1:0] rom_addr(
    input logic [ADDR_W-1:0] base,
    input logic [3:0]        bank,
    input logic [IMG_AW-1:0] addr
  );
    return base + ADDR_W'({bank, addr});
  endfunction

endpackage

// File: rtl/iecdrv_rom_arb_if.sv
// Backing-memory read port of the drive ROM loader.
// Level request, single-cycle ack with data.
interface iecdrv_rom_arb_if;
  import iecdrv_pkg::*;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_dout;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_ack,
    input  mem_dout
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_ack,
    output mem_dout
  );

endinterface

// File: rtl/iecdrv_rr_arb.sv
// Combinational round-robin pick: first requester above last,
// wrapping to the lowest requester.
module iecdrv_rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          hit_hi;
  logic          hit_lo;
  logic [IW-1:0] idx_hi;
  logic [IW-1:0] idx_lo;

  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = IW'(i);
        hit_lo = 1'b1;
        if (i > int'(last)) begin
          idx_hi = IW'(i);
          hit_hi = 1'b1;
        end
      end
    end
    idx = hit_hi ? idx_hi : idx_lo;
    gnt = '0;
    if (hit_lo) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/iecdrv_rom_arb.sv
// Fills drive ROM images from backing memory, one owner at a time,
// holding the grant until that drive stops requesting.
module iecdrv_rom_arb
  import iecdrv_pkg::*;
#(
  parameter int              NDRV = 2,
  parameter logic [ADDR_W-1:0] BASE = 25'h0,
  parameter int              TMO  = 4095
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic [NDRV-1:0]             drv_req,
  input  logic [NDRV-1:0][3:0]        drv_bank,
  input  logic [NDRV-1:0][IMG_AW-1:0] drv_addr,
  output logic [NDRV-1:0]             drv_wr,
  output logic [7:0]                  drv_data,
  iecdrv_rom_arb_if.master            mem,
  output logic [NDRV-1:0]             grant,
  output logic                        busy,
  output logic                        err
);

  localparam int IW = (NDRV > 1) ? $clog2(NDRV) : 1;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  state_e            state_q, state_d;
  logic [NDRV-1:0]   grant_q, grant_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     last_q, last_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;

  logic [NDRV-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              req_g;

  iecdrv_rr_arb #(
    .N  (NDRV),
    .IW (IW)
  ) u_rr (
    .req  (drv_req),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign req_g = drv_req[gidx_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    drop_d  = drop_q;
    unique case (state_q)
      S_IDLE: begin
        if (|drv_req) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          last_d  = arb_idx;
          drop_d  = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (!rd_q) begin
          // first READ cycle: sample the owner's address afresh
          if (!req_g) begin
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            addr_d = rom_addr(BASE, drv_bank[gidx_q],
                              drv_addr[gidx_q]);
            rd_d   = 1'b1;
            tmo_d  = '0;
            drop_d = 1'b0;
          end
        end else begin
          drop_d = drop_q | ~req_g;
          if (mem.mem_ack) begin
            rd_d = 1'b0;
            if (drop_d) begin
              grant_d = '0;
              state_d = S_IDLE;
            end else begin
              data_d  = mem.mem_dout;
              state_d = S_WRITE;
            end
          end else if (tmo_q == TMO_LAST) begin
            rd_d    = 1'b0;
            err_d   = 1'b1;
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      S_WRITE: state_d = S_GAP;
      S_GAP: begin
        if (req_g) begin
          state_d = S_READ;
        end else begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NDRV - 1);
      rd_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  // in IDLE the winner is shown as soon as it requests
  assign grant = (state_q == S_IDLE)
               ? (reset_n ? arb_gnt : '0)
               : grant_q;

  assign drv_wr       = (state_q == S_WRITE) ? grant_q : '0;
  assign drv_data     = data_q;
  assign busy         = (state_q != S_IDLE);
  assign err          = err_q;
  assign mem.mem_rd   = rd_q;
  assign mem.mem_addr = addr_q;

endmodule

// File: tb/tb_iecdrv_rom_arb.sv
// Directed bench for iecdrv_rom_arb: drive and memory
// behaviour modelled in-line, checks at the falling edge.
module tb_iecdrv_rom_arb;

  localparam logic [24:0] TB_BASE = 25'h0;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       drv_req;
  logic [1:0][3:0]  drv_bank;
  logic [1:0][14:0] drv_addr;
  logic [1:0]       drv_wr;
  logic [7:0]       drv_data;
  logic [1:0]       grant;
  logic             busy;
  logic             err;

  iecdrv_rom_arb_if mem_if ();

  iecdrv_rom_arb #(
    .NDRV (2),
    .BASE (TB_BASE),
    .TMO  (15)
  ) dut (
    .clk_sys  (clk),
    .reset_n  (reset_n),
    .drv_req  (drv_req),
    .drv_bank (drv_bank),
    .drv_addr (drv_addr),
    .drv_wr   (drv_wr),
    .drv_data (drv_data),
    .mem      (mem_if),
    .grant    (grant),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc_n = 0;
  int          lat   = 3;
  int          rd_cnt = 0;
  int          wr_cnt [2];
  int          tgt    [2];
  int          last_wr[2];
  bit          chk_per;
  logic        prev_rd = 1'b0;
  logic [24:0] prev_addr = '0;

  function automatic logic [7:0] mdat(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      wr_cnt[i]  = 0;
      last_wr[i] = 0;
      tgt[i]     = 0;
    end
    chk_per = 1'b0;
  endtask

  // one clock: invariants, drive model, memory model
  task automatic cyc();
    logic [24:0] ea;
    @(negedge clk);
    cyc_n++;
    chk("gnt_onehot0", 32'($onehot0(grant)), 32'd1);
    chk("wr_in_gnt", 32'(drv_wr & ~grant), 32'd0);
    if (mem_if.mem_rd && prev_rd)
      chk("addr_stable", 32'(mem_if.mem_addr), 32'(prev_addr));
    prev_rd   = mem_if.mem_rd;
    prev_addr = mem_if.mem_addr;
    for (int i = 0; i < 2; i++) begin
      if (drv_wr[i]) begin
        ea = TB_BASE + 25'(drv_bank[i]) * 25'd32768
           + 25'(drv_addr[i]);
        chk("wr_addr", 32'(mem_if.mem_addr), 32'(ea));
        chk("wr_data", 32'(drv_data), 32'(mdat(ea)));
        if (chk_per && last_wr[i] != 0)
          chk("period", 32'(cyc_n - last_wr[i]), 32'd6);
        last_wr[i]  = cyc_n;
        wr_cnt[i]++;
        drv_addr[i] = drv_addr[i] + 15'd1;
        if (wr_cnt[i] == tgt[i]) drv_req[i] = 1'b0;
      end
    end
    if (mem_if.mem_rd) rd_cnt++;
    else rd_cnt = 0;
    mem_if.mem_ack  = (lat != 0) && (rd_cnt == lat);
    mem_if.mem_dout = mem_if.mem_ack ? mdat(mem_if.mem_addr) : 8'h00;
  endtask

  task automatic run_idle(input string tag, input int bound);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      cyc();
      if (drv_req == 2'b00 && busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_rd(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (mem_if.mem_rd) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_rd"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int  n;
    bit  ok;
    reset_n = 1'b0;
    drv_req = 2'b00;
    drv_bank = '0;
    drv_addr = '0;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_dout = 8'h00;
    clr();

    // reset state
    cyc();
    cyc();
    chk("rst_mem_rd", 32'(mem_if.mem_rd), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr", 32'(drv_wr), 32'd0);
    chk("rst_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("rst_data", 32'(drv_data), 32'd0);
    reset_n = 1'b1;
    cyc();

    // single drive, bank 2 from address 0
    clr();
    lat = 3;
    chk_per = 1'b1;
    tgt[0] = 4;
    drv_bank[0] = 4'd2;
    drv_addr[0] = 15'd0;
    drv_req[0] = 1'b1;
    #1;
    chk("s1_idle_gnt", 32'(grant), 32'd1);
    cyc();
    chk("s1_gnt", 32'(grant), 32'd1);
    chk("s1_rd_early", 32'(mem_if.mem_rd), 32'd0);
    chk("s1_busy", 32'(busy), 32'd1);
    cyc();
    chk("s1_rd", 32'(mem_if.mem_rd), 32'd1);
    chk("s1_addr", 32'(mem_if.mem_addr), 32'h10000);
    run_idle("s1", 200);
    chk("s1_wr_cnt", 32'(wr_cnt[0]), 32'd4);
    chk("s1_gnt_end", 32'(grant), 32'd0);

    // end of image: 0x17FFD..0x17FFF
    clr();
    chk_per = 1'b1;
    tgt[0] = 3;
    drv_addr[0] = 15'd32765;
    drv_req[0] = 1'b1;
    run_idle("s2", 200);
    chk("s2_wr_cnt", 32'(wr_cnt[0]), 32'd3);
    chk("s2_addr_last", 32'(mem_if.mem_addr), 32'h17FFF);

    // round robin after drive 0: drive 1 first
    clr();
    lat = 2;
    tgt[0] = 1;
    tgt[1] = 1;
    drv_bank[0] = 4'd0;
    drv_bank[1] = 4'd5;
    drv_addr[0] = 15'h0040;
    drv_addr[1] = 15'h0123;
    drv_req = 2'b11;
    #1;
    chk("rr_first", 32'(grant), 32'd2);
    run_idle("rr", 100);
    chk("rr_wr0", 32'(wr_cnt[0]), 32'd1);
    chk("rr_wr1", 32'(wr_cnt[1]), 32'd1);

    // contention out of reset
    clr();
    lat = 3;
    reset_n = 1'b0;
    tgt[0] = 3;
    tgt[1] = 2;
    drv_bank[0] = 4'd1;
    drv_bank[1] = 4'd3;
    drv_addr[0] = 15'h0100;
    drv_addr[1] = 15'h0000;
    drv_req = 2'b11;
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("ct_gnt0", 32'(grant), 32'd1);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (grant == 2'b10) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ct_gnt1_seen", 32'(ok), 32'd1);
    chk("ct_wr0_full", 32'(wr_cnt[0]), 32'd3);
    chk("ct_wr1_none", 32'(wr_cnt[1]), 32'd0);
    cyc();
    cyc();
    chk("ct_rd1", 32'(mem_if.mem_rd), 32'd1);
    chk("ct_addr1", 32'(mem_if.mem_addr), 32'h18000);
    run_idle("ct", 100);
    chk("ct_wr1", 32'(wr_cnt[1]), 32'd2);

    // abort: request drops while the read is outstanding
    clr();
    lat = 5;
    tgt[0] = 100;
    drv_bank[0] = 4'd0;
    drv_addr[0] = 15'h0010;
    drv_req[0] = 1'b1;
    wait_rd("ab");
    drv_req[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("ab_rd_hold", 32'(mem_if.mem_rd), 32'd1);
    end
    cyc();
    chk("ab_rd_drop", 32'(mem_if.mem_rd), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_gnt", 32'(grant), 32'd0);
    chk("ab_no_wr", 32'(wr_cnt[0]), 32'd0);
    chk("ab_err", 32'(err), 32'd0);

    // timeout: ack never comes
    clr();
    lat = 0;
    tgt[0] = 100;
    drv_req[0] = 1'b1;
    wait_rd("to");
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!mem_if.mem_rd) break;
      n++;
      cyc();
    end
    drv_req[0] = 1'b0;
    #1;
    chk("to_cycles", 32'(n), 32'd15);
    chk("to_err", 32'(err), 32'd1);
    chk("to_gnt", 32'(grant), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_no_wr", 32'(wr_cnt[0]), 32'd0);
    cyc();
    cyc();
    chk("to_err_sticky", 32'(err), 32'd1);

    // reset mid-READ, then a late ack
    clr();
    tgt[0] = 100;
    drv_req[0] = 1'b1;
    wait_rd("rr2");
    cyc();
    cyc();
    reset_n = 1'b0;
    cyc();
    chk("mr_rd", 32'(mem_if.mem_rd), 32'd0);
    chk("mr_gnt", 32'(grant), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    chk("mr_addr", 32'(mem_if.mem_addr), 32'd0);
    reset_n = 1'b1;
    drv_req[0] = 1'b0;
    mem_if.mem_ack  = 1'b1;
    mem_if.mem_dout = 8'hA5;
    cyc();
    chk("mr_late_busy", 32'(busy), 32'd0);
    chk("mr_late_data", 32'(drv_data), 32'd0);
    chk("mr_late_rd", 32'(mem_if.mem_rd), 32'd0);
    cyc();
    chk("mr_no_wr", 32'(wr_cnt[0]), 32'd0);
    chk("mr_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
